mux_scan_sequencer: RTL and testbench

- Sequencer that drives the select input of the bit-select mux datapath.
- Steps the select through a programmed channel range, waits a programmable settle time on each channel, then samples the selected bit.
- Packs the sampled bits into a capture word and hands it off on a valid/ready interface.
- Sits between the management-side control logic and the mux in the user project area.

---
 rtl/mux_scan_sequencer.sv | 112 +++++++++++
 tb/tb_mux_scan_sequencer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_sequencer.sv
// Scan sequencer for the bit-select mux datapath.
// It steps mux_sel through a latched channel range and waits a settle time on each channel.
// It then samples the returned bit into a capture word, offered on a valid/ready handshake.
module mux_scan_sequencer #(
  parameter int WIDTH     = 32,
  parameter int LOG_WIDTH = 5,
  parameter int DWELL_W   = 8
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 start,
  input  logic                 abort,
  input  logic [LOG_WIDTH-1:0] first_sel,
  input  logic [LOG_WIDTH-1:0] last_sel,
  input  logic [DWELL_W-1:0]   dwell,
  output logic [LOG_WIDTH-1:0] mux_sel,
  input  logic                 mux_out,
  output logic                 busy,
  output logic [WIDTH-1:0]     cap_data,
  output logic                 cap_valid,
  input  logic                 cap_ready,
  output logic                 err
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

  state_t               state;
  logic [LOG_WIDTH-1:0] last_q;
  logic [DWELL_W-1:0]   dwell_q;
  logic [DWELL_W-1:0]   cnt;

  // Scan state machine: every output is a register updated here.
  // Abort outside IDLE takes priority over every other transition, including the DONE handshake.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state     <= IDLE;
      last_q    <= '0;
      dwell_q   <= '0;
      cnt       <= '0;
      mux_sel   <= '0;
      cap_data  <= '0;
      cap_valid <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      err <= 1'b0;
      if (abort && (state != IDLE)) begin
        state     <= IDLE;
        busy      <= 1'b0;
        cap_valid <= 1'b0;
        cap_data  <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (!abort && start) begin
              if (first_sel <= last_sel) begin
                last_q   <= last_sel;
                dwell_q  <= dwell;
                mux_sel  <= first_sel;
                cnt      <= dwell;
                cap_data <= '0;
                busy     <= 1'b1;
                state    <= SETTLE;
              end else begin
                err <= 1'b1;
              end
            end
          end
          SETTLE: begin
            if (cnt == '0) begin
              state <= SAMPLE;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          SAMPLE: begin
            for (int k = 0; k < WIDTH; k++) begin
              if (mux_sel == LOG_WIDTH'(k)) begin
                cap_data[k] <= mux_out;
              end
            end
            if (mux_sel == last_q) begin
              cap_valid <= 1'b1;
              state     <= DONE;
            end else begin
              mux_sel <= mux_sel + 1'b1;
              cnt     <= dwell_q;
              state   <= SETTLE;
            end
          end
          DONE: begin
            if (cap_ready) begin
              cap_valid <= 1'b0;
              busy      <= 1'b0;
              state     <= IDLE;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed testbench for mux_scan_sequencer.
// Each accepted scan pushes its expected word onto a scoreboard queue.
// The entry is popped when cap_valid rises, or dropped when the scan is aborted or reset.
module tb_mux_scan_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [4:0]  first_sel;
  logic [4:0]  last_sel;
  logic [7:0]  dwell;
  logic [4:0]  mux_sel;
  logic        mux_out;
  logic        busy;
  logic [31:0] cap_data;
  logic        cap_valid;
  logic        cap_ready;
  logic        err;

  logic [31:0] pattern = 32'h0;
  logic [31:0] exp_q[$];
  logic [4:0]  sel_log[0:255];
  int          checks = 0;
  int          passed = 0;
  int          latency;
  int          busy_low;
  logic [31:0] held_data;
  int          sel_bad;
  int          valid_seen;

  assign mux_out = pattern[mux_sel];

  always #5 clk = ~clk;

  mux_scan_sequencer #(.WIDTH(32), .LOG_WIDTH(5), .DWELL_W(8)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .start    (start),
    .abort    (abort),
    .first_sel(first_sel),
    .last_sel (last_sel),
    .dwell    (dwell),
    .mux_sel  (mux_sel),
    .mux_out  (mux_out),
    .busy     (busy),
    .cap_data (cap_data),
    .cap_valid(cap_valid),
    .cap_ready(cap_ready),
    .err      (err)
  );

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One comparison: counts it, and reports tag, observed and expected on a miss.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) passed++;
    else $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
  endtask

  // Pulse start for one edge with the given range; an in-range request pushes its expected word.
  task automatic applyStimulus(input logic [4:0] f, input logic [4:0] l, input logic [7:0] d,
                               input logic [31:0] pat);
    logic [31:0] expw;
    pattern   = pat;
    first_sel = f;
    last_sel  = l;
    dwell     = d;
    start     = 1'b1;
    if (f <= l) begin
      expw = '0;
      for (int k = f; k <= int'(l); k++) expw[k] = pat[k];
      exp_q.push_back(expw);
    end
    tick();
    start = 1'b0;
  endtask

  // Count edges until cap_valid rises (bounded), logging mux_sel and busy each cycle.
  task automatic waitCapture(input string tag, input int exp_latency);
    logic [31:0] expw;
    latency  = 0;
    busy_low = 0;
    while (!cap_valid && latency < 2000) begin
      if (latency < 256) sel_log[latency] = mux_sel;
      if (!busy) busy_low++;
      tick();
      latency++;
    end
    checkOutput({tag, "_latency"}, latency, exp_latency);
    checkOutput({tag, "_busy_throughout"}, busy_low, 0);
    if (exp_q.size() > 0) begin
      expw = exp_q.pop_front();
      checkOutput({tag, "_cap_data"}, cap_data, expw);
    end else begin
      checkOutput({tag, "_scoreboard_entry"}, 32'd0, 32'd1);
    end
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    abort     = 1'b0;
    first_sel = '0;
    last_sel  = '0;
    dwell     = '0;
    cap_ready = 1'b0;
    tick();
    tick();
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_cap_valid", cap_valid, 0);
    checkOutput("reset_mux_sel", mux_sel, 0);
    checkOutput("reset_cap_data", cap_data, 0);
    checkOutput("reset_err", err, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Full scan, dwell 0: 32 channels x 2 cycles.
    applyStimulus(5'd0, 5'd31, 8'd0, 32'hA5A51234);
    waitCapture("full", 64);
    cap_ready = 1'b1;
    tick();
    cap_ready = 1'b0;
    checkOutput("full_handshake_valid", cap_valid, 0);
    checkOutput("full_handshake_busy", busy, 0);

    // Partial scan with dwell; inputs are scrambled mid-scan to prove the latched copies are used.
    applyStimulus(5'd4, 5'd7, 8'd3, 32'hFFFFFFFF);
    first_sel = 5'd1;
    last_sel  = 5'd30;
    dwell     = 8'd0;
    waitCapture("partial", 20);
    sel_bad = 0;
    for (int c = 0; c < 20; c++) if (sel_log[c] !== 5'(4 + c / 5)) sel_bad++;
    checkOutput("partial_sel_steps", sel_bad, 0);
    checkOutput("partial_sel_final", mux_sel, 7);

    // Backpressure: DONE holds while cap_ready is low, and start is ignored.
    held_data = 32'h000000F0;
    sel_bad   = 0;
    for (int c = 0; c < 10; c++) begin
      if (c == 4) begin
        first_sel = 5'd0;
        last_sel  = 5'd0;
        start     = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
      if (!cap_valid || cap_data !== held_data || mux_sel !== 5'd7 || !busy) sel_bad++;
    end
    start = 1'b0;
    checkOutput("backpressure_stable", sel_bad, 0);
    cap_ready = 1'b1;
    tick();
    cap_ready = 1'b0;
    checkOutput("backpressure_release_valid", cap_valid, 0);
    checkOutput("backpressure_release_busy", busy, 0);
    tick();
    checkOutput("idle_mux_sel_holds", mux_sel, 7);

    // Invalid range: one-cycle err, nothing else moves.
    applyStimulus(5'd9, 5'd3, 8'd0, 32'h0);
    checkOutput("invalid_err_high", err, 1);
    checkOutput("invalid_busy", busy, 0);
    checkOutput("invalid_mux_sel", mux_sel, 7);
    checkOutput("invalid_cap_data", cap_data, 32'h000000F0);
    tick();
    checkOutput("invalid_err_pulse_ends", err, 0);

    // Abort a full scan once mux_sel reaches 2.
    applyStimulus(5'd0, 5'd31, 8'd0, 32'hFFFFFFFF);
    latency = 0;
    while (mux_sel != 5'd2 && latency < 200) begin
      tick();
      latency++;
    end
    checkOutput("abort_reach_sel2", latency, 4);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_cap_data", cap_data, 0);
    checkOutput("abort_mux_sel_holds", mux_sel, 2);
    valid_seen = 0;
    for (int c = 0; c < 80; c++) begin
      tick();
      if (cap_valid) valid_seen++;
    end
    checkOutput("abort_no_valid", valid_seen, 0);
    applyStimulus(5'd0, 5'd0, 8'd0, 32'h00000001);
    waitCapture("post_abort", 2);

    // Abort together with cap_ready in DONE: the result is discarded.
    abort     = 1'b1;
    cap_ready = 1'b1;
    tick();
    abort     = 1'b0;
    cap_ready = 1'b0;
    checkOutput("abort_vs_ready_valid", cap_valid, 0);
    checkOutput("abort_vs_ready_data", cap_data, 0);

    // Reset during SETTLE of channel 3 clears everything immediately.
    applyStimulus(5'd0, 5'd31, 8'd2, 32'hFFFFFFFF);
    latency = 0;
    while (mux_sel != 5'd3 && latency < 200) begin
      tick();
      latency++;
    end
    checkOutput("reset_mid_reach_sel3", latency, 12);
    @(negedge clk);
    rst = 1'b1;
    #1;
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    checkOutput("reset_mid_busy", busy, 0);
    checkOutput("reset_mid_cap_valid", cap_valid, 0);
    checkOutput("reset_mid_mux_sel", mux_sel, 0);
    checkOutput("reset_mid_cap_data", cap_data, 0);
    @(negedge clk);
    rst = 1'b0;
    busy_low = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (busy || cap_valid) busy_low++;
    end
    checkOutput("reset_mid_no_resume", busy_low, 0);
    checkOutput("scoreboard_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
